// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : instruction fetch stage with IF/ID register, redirect and halt
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] PC_INC = 32'd4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        pcWEN,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  input  logic        halt,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_npc
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;

  logic [31:0] w_pc_inc;
  logic        w_space;
  logic        w_in_fetch;
  logic        w_load;

  assign w_pc_inc   = pc + PC_INC;
  assign w_space    = !valid_q || !stall;
  assign w_in_fetch = !nRST && (state_q == FETCH) && !halt;

  assign imemaddr = pc;
  assign imemREN  = w_in_fetch && !redirect && w_space;
  assign w_load   = imemREN && ihit;
  assign pcWEN    = w_in_fetch && (redirect || w_load);
  // Redirect targets are word-aligned; any other cycle presents the sequential PC.
  assign pc_next  = (w_in_fetch && redirect) ? {redirect_addr[31:2], 2'b00} : w_pc_inc;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q && stall;
    instr_d = instr_q;
    npc_d   = npc_q;
    case (state_q)
      IDLE: begin
        state_d = halt ? HALTED : FETCH;
        if (halt) valid_d = 1'b0;
      end
      FETCH: begin
        if (halt) begin
          state_d = HALTED;
          valid_d = 1'b0;
        end else if (redirect) begin
          valid_d = 1'b0;
        end else if (w_load) begin
          valid_d = 1'b1;
          instr_d = imemload;
          npc_d   = w_pc_inc;
        end
      end
      HALTED: begin
        state_d = HALTED;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      npc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
    end
  end

  assign if_valid = valid_q;
  assign if_instr = instr_q;
  assign if_npc   = npc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST, ihit, redirect, stall, halt;
  logic [31:0] pc, imemload, redirect_addr;
  logic [31:0] pc_next, imemaddr, if_instr, if_npc;
  logic        pcWEN, imemREN, if_valid;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(.PC_INC(32'd4)) dut (
    .CLK(CLK), .nRST(nRST), .pc(pc), .pc_next(pc_next), .pcWEN(pcWEN),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .redirect(redirect), .redirect_addr(redirect_addr), .stall(stall),
    .halt(halt), .if_valid(if_valid), .if_instr(if_instr), .if_npc(if_npc)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle inputs away from it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b1; ihit = 1'b1; redirect = 1'b1; stall = 1'b0; halt = 1'b1;
    pc = 32'h0; imemload = 32'h0; redirect_addr = 32'h40;
    step(); step();
    #1;
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_npc", if_npc, 32'd0);
    chk("rst_pcwen", {31'd0, pcWEN}, 32'd0);
    chk("rst_ren", {31'd0, imemREN}, 32'd0);

    nRST = 1'b0; ihit = 1'b0; redirect = 1'b0; halt = 1'b0;
    #1;
    chk("idle_ren", {31'd0, imemREN}, 32'd0);
    chk("idle_pcwen", {31'd0, pcWEN}, 32'd0);
    step();

    // First fetch hits immediately
    pc = 32'h0; ihit = 1'b1; imemload = 32'hDEADBEEF;
    #1;
    chk("f0_ren", {31'd0, imemREN}, 32'd1);
    chk("f0_pcwen", {31'd0, pcWEN}, 32'd1);
    chk("f0_pcnext", pc_next, 32'h4);
    chk("f0_addr", imemaddr, 32'h0);
    step();
    chk("f0_valid", {31'd0, if_valid}, 32'd1);
    chk("f0_instr", if_instr, 32'hDEADBEEF);
    chk("f0_npc", if_npc, 32'h4);

    // Miss for three cycles
    pc = 32'h10; ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("miss_ren", {31'd0, imemREN}, 32'd1);
      chk("miss_pcwen", {31'd0, pcWEN}, 32'd0);
      chk("miss_pcnext", pc_next, 32'h14);
      step();
      chk("miss_valid", {31'd0, if_valid}, 32'd0);
    end
    ihit = 1'b1; imemload = 32'h11111111;
    #1;
    chk("hit_pcwen", {31'd0, pcWEN}, 32'd1);
    chk("hit_pcnext", pc_next, 32'h14);
    step();
    chk("hit_valid", {31'd0, if_valid}, 32'd1);
    chk("hit_npc", if_npc, 32'h14);

    // Stall holds IF/ID
    pc = 32'h14; stall = 1'b1; imemload = 32'h99999999;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stl_ren", {31'd0, imemREN}, 32'd0);
      chk("stl_pcwen", {31'd0, pcWEN}, 32'd0);
      step();
      chk("stl_valid", {31'd0, if_valid}, 32'd1);
      chk("stl_instr", if_instr, 32'h11111111);
      chk("stl_npc", if_npc, 32'h14);
    end
    stall = 1'b0; imemload = 32'h22222222;
    #1;
    chk("res_ren", {31'd0, imemREN}, 32'd1);
    chk("res_pcwen", {31'd0, pcWEN}, 32'd1);
    step();
    chk("res_instr", if_instr, 32'h22222222);
    chk("res_npc", if_npc, 32'h18);

    // Redirect flushes despite stall and ihit
    pc = 32'h18; redirect = 1'b1; redirect_addr = 32'h00000123; stall = 1'b1; ihit = 1'b1;
    #1;
    chk("rd_pcnext", pc_next, 32'h00000120);
    chk("rd_pcwen", {31'd0, pcWEN}, 32'd1);
    chk("rd_ren", {31'd0, imemREN}, 32'd0);
    step();
    chk("rd_valid", {31'd0, if_valid}, 32'd0);

    // PC wrap
    redirect = 1'b0; stall = 1'b0; pc = 32'hFFFFFFFC; imemload = 32'h33333333;
    #1;
    chk("wrap_pcnext", pc_next, 32'h0);
    chk("wrap_pcwen", {31'd0, pcWEN}, 32'd1);
    step();
    chk("wrap_npc", if_npc, 32'h0);
    chk("wrap_valid", {31'd0, if_valid}, 32'd1);

    // Halt beats redirect
    halt = 1'b1; redirect = 1'b1; redirect_addr = 32'h80;
    #1;
    chk("hlt_pcwen", {31'd0, pcWEN}, 32'd0);
    chk("hlt_ren", {31'd0, imemREN}, 32'd0);
    step();
    chk("hlt_valid", {31'd0, if_valid}, 32'd0);
    halt = 1'b0; ihit = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("hltd_pcwen", {31'd0, pcWEN}, 32'd0);
      chk("hltd_ren", {31'd0, imemREN}, 32'd0);
      step();
      chk("hltd_valid", {31'd0, if_valid}, 32'd0);
    end
    redirect = 1'b0;

    // Reset mid-operation
    nRST = 1'b1; step(); nRST = 1'b0; step();
    pc = 32'h40; ihit = 1'b1; imemload = 32'h44444444;
    step();
    chk("mr_valid1", {31'd0, if_valid}, 32'd1);
    ihit = 1'b0; pc = 32'h44;
    #1;
    chk("mr_ren_pre", {31'd0, imemREN}, 32'd1);
    nRST = 1'b1; ihit = 1'b1;
    #1;
    chk("mr_pcwen", {31'd0, pcWEN}, 32'd0);
    chk("mr_ren", {31'd0, imemREN}, 32'd0);
    step();
    chk("mr_valid", {31'd0, if_valid}, 32'd0);
    chk("mr_instr", if_instr, 32'd0);
    nRST = 1'b0;
    #1;
    chk("mr_idle_ren", {31'd0, imemREN}, 32'd0);
    chk("mr_idle_pcwen", {31'd0, pcWEN}, 32'd0);
    step();
    #1;
    chk("mr_fetch_ren", {31'd0, imemREN}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
